serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal values are 2 or more.
REQ-002 SHALL have parameter BPC, default 1: bits processed per cycle; legal values are 1 to WIDTH, and WIDTH must be a multiple of BPC.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: operation request.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: minuend and subtrahend.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 SHALL have port diff, output, WIDTH bits: difference a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1 bit: borrow-out; 1 when a < b + bin (unsigned).
REQ-012 SHALL have port ovf, output, 1 bit: signed overflow; present only under SUB_OVF_EN.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; when accepted, it latches a, b and bin, clears the step counter and enters RUN.
REQ-015 SHALL ignore start while in RUN; the latched operands stay unchanged.
REQ-016 SHALL, in each RUN cycle, subtract the next BPC bits (LSB first) through a chain of BPC 1-bit cells, register the partial difference, and carry the borrow to the next step.
REQ-017 SHALL take exactly N = WIDTH/BPC RUN cycles; after the last step it goes RUN->DONE.
REQ-018 SHALL have fixed latency: start accepted at edge 0 -> busy=1 in cycles 1..N, then done=1 and busy=0 in cycle N+1.
REQ-019 SHALL go DONE->IDLE after one cycle, or DONE->RUN if start=1 in that cycle (back-to-back operation, no idle gap).
REQ-020 SHALL hold diff, bout and ovf stable from the done cycle until the next done pulse; during RUN they keep the previous result.
REQ-021 SHALL keep done and busy mutually exclusive.
REQ-022 SHALL wrap all arithmetic modulo 2^WIDTH and flag no error other than bout and ovf.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, force: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0.
REQ-024 SHALL give rst priority over start; start asserted in the same cycle as rst is dropped.
REQ-025 SHALL abort any operation in progress on rst, with no done pulse and no partial result on the outputs.

Configuration
REQ-026 SHALL use macro SUB_OVF_EN: when defined, port ovf exists and is set at done to (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the latched operands.
REQ-027 SHALL, when SUB_OVF_EN is undefined, omit port ovf and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the counter width function (clog2 of WIDTH/BPC) in shared package sub_pkg.
REQ-029 SHALL instantiate sub-module sub_cell, a 1-bit full subtractor (diff = x^y^bi; bo = (~x&y) | (~(x^y)&bi)), BPC times in a chain.
REQ-030 SHALL fail elaboration with an error when WIDTH % BPC != 0 or WIDTH < 2.

Verification
REQ-031 SHALL cover: WIDTH=8, BPC=1, a=0x05, b=0x03, bin=0 -> busy in cycles 1-8, done in cycle 9, diff=0x02, bout=0.
REQ-032 SHALL cover: a=0x00, b=0x01, bin=1 -> diff=0xFE, bout=1.
REQ-033 SHALL cover: SUB_OVF_EN defined, a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1, bout=0.
REQ-034 SHALL cover: WIDTH=8, BPC=4, a=0xA5, b=0x5A -> done in cycle 3, diff=0x4B, bout=0.
REQ-035 SHALL cover: start pulsed again in cycle 4 of a run -> ignored, first result correct; start held through the done cycle -> next operation starts, busy=1 in the following cycle.
REQ-036 SHALL cover: rst in cycle 5 of a run -> next cycle IDLE, all outputs 0, no done pulse; a new start after that completes correctly.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types for the serial subtractor: FSM state encoding and step-counter sizing.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes WIDTH/BPC steps; never narrower than one bit.
    function automatic int cnt_width(input int width, input int bpc);
        int steps;
        if (bpc < 1) begin
            return 1;
        end
        steps = width / bpc;
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/sub_cell.sv
// 1-bit full subtractor cell: diff = x - y - bi, bo = borrow out. Purely combinational.
module sub_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Serial a - b - bin, BPC bits per cycle LSB first; result after WIDTH/BPC RUN cycles, done one cycle later.
// start is only taken in IDLE/DONE (ignored while busy); SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = cnt_width(WIDTH, BPC);

    generate
        if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BPC (WIDTH=%0d BPC=%0d)",
                   WIDTH, BPC);
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             brw;
    logic [BPC-1:0]   cell_d;
    logic [BPC:0]     chain;
    logic             last_step;
    logic             accept;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Ripple chain for this step; the borrow leaving the top cell feeds the next step.
    assign chain[0] = brw;

    generate
        for (genvar i = 0; i < BPC; i++) begin : g_cell
            sub_cell u_cell (
                .x    (a_sh[i]),
                .y    (b_sh[i]),
                .bi   (chain[i]),
                .diff (cell_d[i]),
                .bo   (chain[i+1])
            );
        end
    endgenerate

    // Partial differences enter at the top and slide down, so the LSB step ends up at bit 0.
    generate
        if (BPC == WIDTH) begin : g_acc_full
            assign acc_nxt = cell_d;
        end else begin : g_acc_shift
            assign acc_nxt = {cell_d, acc[WIDTH-1:BPC]};
        end
    endgenerate

    assign last_step = (cnt == CW'(N - 1));
    assign accept    = start && (state != RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            brw   <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                brw   <= bin;
                cnt   <= '0;
`ifdef SUB_OVF_EN
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
`endif
            end else if (state == RUN) begin
                a_sh <= a_sh >> BPC;
                b_sh <= b_sh >> BPC;
                acc  <= acc_nxt;
                brw  <= chain[BPC];
                cnt  <= cnt + CW'(1);
                // Outputs only change on completion, so they hold the old result while running.
                if (last_step) begin
                    diff <= acc_nxt;
                    bout <= chain[BPC];
`ifdef SUB_OVF_EN
                    ovf  <= (a_msb != b_msb) && (acc_nxt[WIDTH-1] != a_msb);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: two instances (BPC=1 and BPC=4) against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start1;
    logic         start4;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy1, done1, bout1;
    logic         busy4, done4, bout4;
    logic [W-1:0] diff1, diff4;
`ifdef SUB_OVF_EN
    logic         ovf1, ovf4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] prev_d [2];
    logic         prev_b [2];
    logic         prev_o [2];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W), .BPC(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    serial_subtractor #(.WIDTH(W), .BPC(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic bi);
        int r;
        r = int'(x) - int'(y) - int'(bi);
        return r[W-1:0];
    endfunction

    function automatic logic m_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        return int'(x) < (int'(y) + int'(bi));
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W-1:0] d;
        d = m_diff(x, y, bi);
        return (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    endfunction

    task automatic expect_out(input int sel, input string tag, input logic ebusy, input logic edone,
                              input logic [W-1:0] ediff, input logic ebout, input logic eovf);
        logic         bsy, dn, bo;
        logic [W-1:0] d;
        if (sel == 0) begin
            bsy = busy1; dn = done1; d = diff1; bo = bout1;
        end else begin
            bsy = busy4; dn = done4; d = diff4; bo = bout4;
        end
        check($sformatf("%s.busy", tag), 32'(bsy), 32'(ebusy));
        check($sformatf("%s.done", tag), 32'(dn), 32'(edone));
        check($sformatf("%s.diff", tag), 32'(d), 32'(ediff));
        check($sformatf("%s.bout", tag), 32'(bo), 32'(ebout));
`ifdef SUB_OVF_EN
        check($sformatf("%s.ovf", tag), 32'((sel == 0) ? ovf1 : ovf4), 32'(eovf));
`else
        if (eovf === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
    endtask

    task automatic set_prev(input int sel, input logic [W-1:0] d, input logic bo, input logic ov);
        prev_d[sel] = d;
        prev_b[sel] = bo;
        prev_o[sel] = ov;
    endtask

    // One full operation: start at edge 0, busy for n cycles, done at n+1, held afterwards.
    task automatic do_op(input int sel, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbi, input string tag);
        int           n;
        logic [W-1:0] ed;
        logic         eb, eo;
        n  = (sel == 0) ? W : W / 4;
        ed = m_diff(ta, tb_, tbi);
        eb = m_bout(ta, tb_, tbi);
        eo = m_ovf(ta, tb_, tbi);
        @(negedge clk);
        a = ta; b = tb_; bin = tbi;
        if (sel == 0) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        for (int c = 1; c <= n; c++) begin
            expect_out(sel, $sformatf("%s.run%0d", tag, c), 1'b1, 1'b0,
                       prev_d[sel], prev_b[sel], prev_o[sel]);
            @(posedge clk); #1;
        end
        expect_out(sel, {tag, ".res"}, 1'b0, 1'b1, ed, eb, eo);
        set_prev(sel, ed, eb, eo);
        @(posedge clk); #1;
        expect_out(sel, {tag, ".hold"}, 1'b0, 1'b0, ed, eb, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start1 = 1'b1; start4 = 1'b1;
        a = 8'h5A; b = 8'h11; bin = 1'b1;
        set_prev(0, '0, 1'b0, 1'b0);
        set_prev(1, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_out(0, "reset1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        expect_out(1, "reset4", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0; start1 = 1'b0; start4 = 1'b0;
        @(posedge clk); #1;
        expect_out(0, "post_reset1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        do_op(0, 8'h05, 8'h03, 1'b0, "basic");
        check("basic.const_diff", 32'(diff1), 32'h02);
        do_op(0, 8'h00, 8'h01, 1'b1, "underflow");
        check("underflow.const_diff", 32'(diff1), 32'hFE);
        check("underflow.const_bout", 32'(bout1), 32'h1);
        do_op(0, 8'h80, 8'h01, 1'b0, "sovf");
        check("sovf.const_diff", 32'(diff1), 32'h7F);
        do_op(1, 8'hA5, 8'h5A, 1'b0, "bpc4");
        check("bpc4.const_diff", 32'(diff4), 32'h4B);

        // start pulsed mid-run must not disturb the operation in flight
        @(negedge clk);
        a = 8'h3C; b = 8'h11; bin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= W; c++) begin
            expect_out(0, $sformatf("ignore.run%0d", c), 1'b1, 1'b0, prev_d[0], prev_b[0], prev_o[0]);
            if (c == 4) begin start1 = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1; end
            if (c == 5) start1 = 1'b0;
            @(posedge clk); #1;
        end
        expect_out(0, "ignore.res", 1'b0, 1'b1, 8'h2B, 1'b0, m_ovf(8'h3C, 8'h11, 1'b0));
        set_prev(0, 8'h2B, 1'b0, m_ovf(8'h3C, 8'h11, 1'b0));
        @(posedge clk); #1;

        // start held through the done cycle chains straight into the next operation
        @(negedge clk);
        a = 8'h10; b = 8'h20; bin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= W; c++) begin
            expect_out(0, $sformatf("b2b.run%0d", c), 1'b1, 1'b0, prev_d[0], prev_b[0], prev_o[0]);
            if (c == W) begin start1 = 1'b1; a = 8'h77; b = 8'h07; bin = 1'b1; end
            @(posedge clk); #1;
        end
        expect_out(0, "b2b.res1", 1'b0, 1'b1, 8'hF0, 1'b1, m_ovf(8'h10, 8'h20, 1'b0));
        @(posedge clk); #1;
        start1 = 1'b0;
        expect_out(0, "b2b.restart", 1'b1, 1'b0, 8'hF0, 1'b1, m_ovf(8'h10, 8'h20, 1'b0));
        for (int c = 2; c <= W; c++) begin
            @(posedge clk); #1;
            check($sformatf("b2b.busy2_%0d", c), 32'(busy1), 32'h1);
        end
        @(posedge clk); #1;
        expect_out(0, "b2b.res2", 1'b0, 1'b1, 8'h6F, 1'b0, m_ovf(8'h77, 8'h07, 1'b1));
        set_prev(0, 8'h6F, 1'b0, m_ovf(8'h77, 8'h07, 1'b1));
        @(posedge clk); #1;

        // reset mid-run aborts without a done pulse and clears the outputs
        @(negedge clk);
        a = 8'h44; b = 8'h22; bin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            expect_out(0, $sformatf("abort.run%0d", c), 1'b1, 1'b0, prev_d[0], prev_b[0], prev_o[0]);
            if (c == 5) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        set_prev(0, '0, 1'b0, 1'b0);
        set_prev(1, '0, 1'b0, 1'b0);
        expect_out(0, "abort.cleared", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int c = 0; c < W; c++) begin
            @(posedge clk); #1;
            expect_out(0, $sformatf("abort.idle%0d", c), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        do_op(0, 8'h9A, 8'h3B, 1'b1, "after_rst");

        for (int i = 0; i < 25; i++) begin
            do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd1_%0d", i));
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd4_%0d", i));
        end
        do_op(1, 8'h00, 8'hFF, 1'b1, "bpc4_edge");
        do_op(0, 8'hFF, 8'hFF, 1'b1, "edge_ff");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
